// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32 front-end fetch control.
//   Decides each cycle whether the external PC steps (+4), holds or is
//   redirected. Keeps one instruction-memory read outstanding at a time.
//   Returned words are queued in a BUF_DEPTH-entry FIFO, each tagged with its
//   PC, for decode. A redirect flushes the FIFO and any in-flight fetch.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   pc_address               current PC value (PC register lives outside)
//   pc_load, pc_new_address  PC load control; when pc_load=0 the PC steps by 4
//   imem_req_*               request channel (valid/ready, address)
//   imem_rsp_*               response channel (1-cycle pulse, always accepted)
//   redirect_valid/addr      redirect from execute; highest priority
//   inst_valid/ready/data/pc FIFO head toward decode
//   fetch_misaligned         only with FETCH_MISALIGN_CHECK_EN defined
// Build option FETCH_MISALIGN_CHECK_EN: when defined, a misaligned redirect
// target is loaded as-is and stalls fetching until an aligned redirect. When
// undefined, the redirect target has bits [1:0] forced to zero.
module fetch_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] CODE_START = 32'h0000_8000,
  parameter int unsigned     BUF_DEPTH  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_address,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_new_address,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_misaligned,
`endif
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned PW      = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = BUF_DEPTH[PW:0];

  logic [1:0]      state_q, state_d;
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] buf_pc_q   [BUF_DEPTH];
  logic [31:0]     buf_data_q [BUF_DEPTH];

  logic            push, pop;
  logic [XLEN-1:0] redir_target;
  logic            mis_q, mis_d;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_target = redirect_addr;
  assign mis_d        = redirect_valid ? (redirect_addr[1:0] != 2'b00) : mis_q;
  assign fetch_misaligned = reset_n & mis_q;
`else
  assign redir_target = redirect_addr & ~XLEN'(3);
  assign mis_d        = 1'b0;
`endif

  assign inst_valid = reset_n & (count_q != '0);
  assign inst_data  = reset_n ? buf_data_q[rd_q] : '0;
  assign inst_pc    = reset_n ? buf_pc_q[rd_q]   : '0;
  assign pop        = inst_valid & inst_ready;

  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    pc_load        = 1'b1;
    pc_new_address = pc_address;
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_address;
    push           = 1'b0;

    case (state_q)
      ISSUE: begin
        imem_req_valid = (count_q < DEPTH_C) & ~redirect_valid & ~mis_q;
        if (imem_req_valid && imem_req_ready) begin
          pc_load  = 1'b0;
          req_pc_d = pc_address;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    // A redirect wins over everything; a response arriving with it is dropped,
    // and an in-flight read with no response yet must be drained first.
    if (redirect_valid) begin
      pc_load        = 1'b1;
      pc_new_address = redir_target;
      push           = 1'b0;
      state_d        = (state_q != ISSUE && !imem_rsp_valid) ? DRAIN : ISSUE;
    end

    if (!reset_n) begin
      pc_load        = 1'b0;
      pc_new_address = '0;
      imem_req_valid = 1'b0;
      imem_req_addr  = '0;
      push           = 1'b0;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (redirect_valid) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ISSUE;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      req_pc_q <= CODE_START;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      req_pc_q <= req_pc_d;
      mis_q    <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_q]   <= req_pc_q;
      buf_data_q[wr_q] <= imem_rsp_data;
    end
  end

endmodule
